// File: rtl/video_write_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | video_write_sched: arbitrates the video FIFO write port between the PPU  |
// | pixel stream and a solid-colour fill engine, frame by frame.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module video_write_sched #(
  parameter int H_PIX      = 256,
  parameter int V_LINES    = 240,
  parameter int FIFO_DEPTH = 512,
  parameter int HEADROOM   = 4
) (
  input  logic       cpu_clk,
  input  logic       reset,
  input  logic       ppu_valid,
  input  logic [5:0] ppu_code,
  output logic       ppu_ready,
  input  logic       fill_start,
  input  logic [5:0] fill_code,
  output logic       fill_busy,
  input  logic [9:0] fifo_level,
  output logic       fifo_write,
  output logic [5:0] fifo_din,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       frame_done
);

  localparam logic [9:0] WR_LIMIT = 10'(FIFO_DEPTH - HEADROOM);
  localparam logic [7:0] X_LAST   = 8'(H_PIX - 1);
  localparam logic [7:0] Y_LAST   = 8'(V_LINES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       fill_pend_q, fill_pend_d;
  logic [5:0] fill_reg_q, fill_reg_d;
  logic [7:0] pix_x_q, pix_x_d;
  logic [7:0] pix_y_q, pix_y_d;
  logic       fifo_write_q, fifo_write_d;
  logic [5:0] fifo_din_q, fifo_din_d;
  logic       frame_done_q, frame_done_d;

  logic can_write;
  logic ppu_accept;
  logic fill_beat;
  logic advance;

  assign can_write = (fifo_level < WR_LIMIT);

  // A fill request arriving in IDLE already blocks the PPU so the fill wins the tie.
  assign ppu_ready = reset & can_write &
                     ((state_q == ST_STREAM) |
                      ((state_q == ST_IDLE) & ~fill_pend_q & ~fill_start));

  assign ppu_accept = ppu_valid & ppu_ready;
  assign fill_beat  = (state_q == ST_FILL) & can_write;
  assign advance    = ppu_accept | fill_beat;

  always_comb begin
    state_d      = state_q;
    fill_pend_d  = fill_pend_q;
    fill_reg_d   = fill_reg_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    fifo_write_d = advance;
    fifo_din_d   = fifo_din_q;
    frame_done_d = 1'b0;

    if (advance) begin
      fifo_din_d = ppu_accept ? ppu_code : fill_reg_q;
      if (state_q == ST_IDLE) begin
        state_d = ST_STREAM;
      end
      if (pix_x_q == X_LAST) begin
        pix_x_d = '0;
        if (pix_y_q == Y_LAST) begin
          pix_y_d      = '0;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          pix_y_d = pix_y_q + 8'd1;
        end
      end else begin
        pix_x_d = pix_x_q + 8'd1;
      end
    end else if ((state_q == ST_IDLE) && fill_pend_q) begin
      state_d     = ST_FILL;
      fill_pend_d = 1'b0;
    end

    // A new request always re-arms, even on the cycle the previous one is consumed.
    if (fill_start) begin
      fill_pend_d = 1'b1;
      fill_reg_d  = fill_code;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      fill_pend_q  <= 1'b0;
      fill_reg_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      fifo_write_q <= 1'b0;
      fifo_din_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_pend_q  <= fill_pend_d;
      fill_reg_q   <= fill_reg_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      fifo_write_q <= fifo_write_d;
      fifo_din_q   <= fifo_din_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fill_busy  = fill_pend_q | (state_q == ST_FILL);
  assign fifo_write = fifo_write_q;
  assign fifo_din   = fifo_din_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_video_write_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_video_write_sched: small-raster instance against a reference model,   |
// | plus a full-size instance streaming one complete 256x240 frame.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_video_write_sched;

  localparam int SH = 4;
  localparam int SV = 3;
  localparam int SN = SH * SV;
  localparam int LIMIT = 512 - 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- small-raster DUT ----------------
  logic       s_reset, s_valid, s_ready, s_fs, s_busy, s_wr, s_fd;
  logic [5:0] s_code, s_fc, s_din;
  logic [9:0] s_level;
  logic [7:0] s_x, s_y;

  video_write_sched #(.H_PIX(SH), .V_LINES(SV), .FIFO_DEPTH(512), .HEADROOM(4)) dut_s (
    .cpu_clk(clk), .reset(s_reset), .ppu_valid(s_valid), .ppu_code(s_code),
    .ppu_ready(s_ready), .fill_start(s_fs), .fill_code(s_fc), .fill_busy(s_busy),
    .fifo_level(s_level), .fifo_write(s_wr), .fifo_din(s_din), .pix_x(s_x),
    .pix_y(s_y), .frame_done(s_fd)
  );

  // ---------------- full-size DUT ----------------
  logic       f_reset, f_valid, f_ready, f_busy, f_wr, f_fd;
  logic [5:0] f_code, f_din;
  logic [7:0] f_x, f_y;
  bit         f_done = 1'b0;

  video_write_sched dut_f (
    .cpu_clk(clk), .reset(f_reset), .ppu_valid(f_valid), .ppu_code(f_code),
    .ppu_ready(f_ready), .fill_start(1'b0), .fill_code(6'd0), .fill_busy(f_busy),
    .fifo_level(10'd0), .fifo_write(f_wr), .fifo_din(f_din), .pix_x(f_x),
    .pix_y(f_y), .frame_done(f_fd)
  );

  // Reference model: mode 0=between frames, 1=PPU frame, 2=fill frame.
  // Position is kept as a linear pixel index; x/y derive from it.
  int m_mode = 0, m_pend = 0, m_col = 0, m_idx = 0, m_wr = 0, m_din = 0, m_fd = 0;
  int wq[$];
  int fq[$];

  always @(negedge clk) begin : cmp
    int  exp_ready;
    bit  can, take_ppu, take_fill;
    can       = (int'(s_level) < LIMIT);
    exp_ready = (s_reset && can && (m_mode == 1 || (m_mode == 0 && m_pend == 0 && !s_fs))) ? 1 : 0;
    chk("ppu_ready", int'(s_ready), exp_ready);
    chk("fifo_write", int'(s_wr), m_wr);
    chk("fifo_din", int'(s_din), m_din);
    chk("frame_done", int'(s_fd), m_fd);
    chk("pix_x", int'(s_x), m_idx % SH);
    chk("pix_y", int'(s_y), m_idx / SH);
    chk("fill_busy", int'(s_busy), (m_pend != 0 || m_mode == 2) ? 1 : 0);
    if (s_wr) begin
      wq.push_back(int'(s_din));
      fq.push_back(int'(s_fd));
    end
    if (!s_reset) begin
      m_mode = 0; m_pend = 0; m_col = 0; m_idx = 0; m_wr = 0; m_din = 0; m_fd = 0;
    end else begin
      take_ppu  = s_valid && (exp_ready != 0);
      take_fill = (m_mode == 2) && can;
      m_wr = (take_ppu || take_fill) ? 1 : 0;
      m_fd = 0;
      if (m_wr != 0) begin
        m_din = take_ppu ? int'(s_code) : m_col;
        if (m_idx == SN - 1) begin
          m_idx = 0; m_fd = 1; m_mode = 0;
        end else begin
          m_idx++;
          if (m_mode == 0) m_mode = 1;
        end
      end else if (m_mode == 0 && m_pend != 0) begin
        m_mode = 2; m_pend = 0;
      end
      if (s_fs) begin
        m_pend = 1; m_col = int'(s_fc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until the model is between frames with nothing pending.
  task automatic finish_frame();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_mode == 0 && m_pend == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("frame_end_bound", int'(done), 1);
  endtask

  // ---------------- full-size frame stream ----------------
  initial begin : full
    int fd_count;
    fd_count = 0;
    f_reset = 1'b0; f_valid = 1'b0; f_code = '0;
    repeat (3) tick();
    f_reset = 1'b1;
    f_valid = 1'b1;
    for (int n = 0; n < 61440; n++) begin
      f_code = 6'(n);
      @(negedge clk);
      chk("full_x", int'(f_x), n % 256);
      chk("full_y", int'(f_y), n / 256);
      chk("full_ready", int'(f_ready), 1);
      if (f_fd) fd_count++;
      if (n > 0) begin
        chk("full_wr", int'(f_wr), 1);
        chk("full_din", int'(f_din), (n - 1) % 64);
      end
      tick();
    end
    f_valid = 1'b0;
    @(negedge clk);
    if (f_fd) fd_count++;
    chk("full_last_wr", int'(f_wr), 1);
    chk("full_last_din", int'(f_din), 63);
    chk("full_last_fd", int'(f_fd), 1);
    chk("full_wrap_x", int'(f_x), 0);
    chk("full_wrap_y", int'(f_y), 0);
    chk("full_fd_count", fd_count, 1);
    f_done = 1'b1;
  end

  // ---------------- small-raster directed + random stimulus ----------------
  initial begin : stim
    int n;
    bit ok;
    s_reset = 1'b0; s_valid = 1'b0; s_code = '0; s_fs = 1'b0; s_fc = '0; s_level = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wr", int'(s_wr), 0);
    chk("rst_din", int'(s_din), 0);
    chk("rst_ready", int'(s_ready), 0);
    chk("rst_busy", int'(s_busy), 0);
    chk("rst_x", int'(s_x), 0);
    chk("rst_y", int'(s_y), 0);
    chk("rst_fd", int'(s_fd), 0);
    tick();
    s_reset = 1'b1;

    // single PPU frame, codes 0..11
    wq.delete(); fq.delete();
    s_valid = 1'b1;
    for (int k = 0; k < SN; k++) begin
      s_code = 6'(k);
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    chk("frame_len", wq.size(), SN);
    for (int i = 0; i < SN && i < wq.size(); i++) begin
      chk("frame_din", wq[i], i);
      chk("frame_fd", fq[i], (i == SN - 1) ? 1 : 0);
    end

    // backpressure at the headroom threshold
    wq.delete(); fq.delete();
    s_level = 10'd508; s_valid = 1'b1; s_code = 6'h15;
    repeat (4) tick();
    @(negedge clk);
    chk("bp_ready_low", int'(s_ready), 0);
    chk("bp_no_writes", wq.size(), 0);
    tick();
    s_level = 10'd507;
    @(negedge clk);
    chk("bp_ready_rise", int'(s_ready), 1);
    tick();
    s_level = 10'd0; s_code = 6'h00;
    @(negedge clk);
    chk("bp_write", int'(s_wr), 1);
    chk("bp_din", int'(s_din), 'h15);
    finish_frame();
    s_valid = 1'b0;
    tick();

    // fill requested after 5 of 12 PPU pixels
    wq.delete(); fq.delete();
    s_valid = 1'b1;
    for (int k = 0; k < SN; k++) begin
      s_code = 6'(32 + k);
      s_fs   = (k == 5);
      s_fc   = 6'h0F;
      tick();
    end
    s_fs = 1'b0;
    finish_frame();
    s_valid = 1'b0;
    tick(); tick();
    chk("midfill_len", wq.size(), 2 * SN);
    for (int i = 0; i < 2 * SN && i < wq.size(); i++)
      chk("midfill_din", wq[i], (i < SN) ? 32 + i : 'h0F);

    // arbitration tie in IDLE
    wq.delete(); fq.delete();
    s_valid = 1'b1; s_code = 6'h03; s_fs = 1'b1; s_fc = 6'h20;
    @(negedge clk);
    chk("tie_ready", int'(s_ready), 0);
    tick();
    s_fs = 1'b0;
    finish_frame();
    tick();
    finish_frame();
    s_valid = 1'b0;
    tick(); tick();
    chk("tie_len", wq.size(), 2 * SN);
    for (int i = 0; i < SN && i < wq.size(); i++)
      chk("tie_fill_din", wq[i], 'h20);
    if (wq.size() > SN) begin
      chk("tie_ppu_after", wq[SN], 3);
      chk("tie_fd_before_ppu", fq[SN - 1], 1);
    end

    // reset in the middle of a fill frame
    wq.delete(); fq.delete();
    s_fs = 1'b1; s_fc = 6'h2A;
    tick();
    s_fs = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (wq.size() >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstfill_bound", int'(ok), 1);
    s_reset = 1'b0;
    tick();
    @(negedge clk);
    chk("rstfill_wr", int'(s_wr), 0);
    chk("rstfill_din", int'(s_din), 0);
    chk("rstfill_ready", int'(s_ready), 0);
    chk("rstfill_busy", int'(s_busy), 0);
    chk("rstfill_x", int'(s_x), 0);
    chk("rstfill_y", int'(s_y), 0);
    chk("rstfill_fd", int'(s_fd), 0);
    n = wq.size();
    tick();
    s_reset = 1'b1;
    repeat (3) tick();
    chk("rstfill_no_writes", wq.size(), n);
    wq.delete(); fq.delete();
    s_valid = 1'b1; s_code = 6'h11;
    finish_frame();
    s_valid = 1'b0;
    tick(); tick();
    chk("rstfill_len", wq.size(), SN);
    if (wq.size() > 0) chk("rstfill_first", wq[0], 'h11);

    // randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(9) < 7);
      s_code  = 6'($urandom);
      s_fs    = ($urandom_range(49) == 0);
      s_fc    = 6'($urandom);
      s_level = ($urandom_range(3) == 0) ? 10'($urandom_range(511, 500)) : 10'($urandom_range(499));
      s_reset = ($urandom_range(399) != 0);
      tick();
    end
    s_reset = 1'b1; s_valid = 1'b0; s_fs = 1'b0; s_level = '0;
    repeat (3) tick();

    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (f_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("full_run_bound", int'(ok), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_write_sched.md
# video_write_sched

Single-clock scheduler that owns the write port of the NES video clock-crossing FIFO on the CPU side. It shares that port between two requesters: the PPU pixel stream and a solid-colour fill engine used for blanking and test screens. It tracks the raster position of every pixel written, switches requesters only on frame boundaries, and throttles writes against the FIFO occupancy so the FIFO never overflows.

## Interface
- H_PIX, 256, pixels per line (2..256)
- V_LINES, 240, lines per frame (2..256)
- FIFO_DEPTH, 512, FIFO capacity in words
- HEADROOM, 4, free words kept in reserve (≥2, covers the registered-write latency)

- cpu_clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset), sampled on cpu_clk
- ppu_valid  in  1  PPU has a pixel on ppu_code
- ppu_code  in  6  PPU colour code
- ppu_ready  out  1  scheduler accepts ppu_code this cycle
- fill_start  in  1  single-cycle request for one full fill frame
- fill_code  in  6  fill colour; sampled when fill_start=1
- fill_busy  out  1  fill pending or in progress
- fifo_level  in  10  current FIFO occupancy, write-side view
- fifo_write  out  1  FIFO write strobe
- fifo_din  out  6  FIFO write data
- pix_x  out  8  column of the next pixel to be accepted
- pix_y  out  8  line of the next pixel to be accepted
- frame_done  out  1  one-cycle pulse with the write of a frame's last pixel

## Operation
- **Write gate:** can_write = (fifo_level < FIFO_DEPTH − HEADROOM).
- **States:**
  - IDLE: at a frame boundary; pix_x = pix_y = 0.
  - STREAM: PPU frame in progress.
  - FILL: fill frame in progress.
- **Pending fill:**
  - fill_start=1 sets fill_pend and loads fill_code into fill_reg in any state.
  - A repeated fill_start while pending overwrites fill_reg.
  - fill_start during FILL queues exactly one further fill frame.
- **IDLE:**
  - If fill_pend: go to FILL and clear fill_pend; no pixel is written this cycle.
  - Otherwise ppu_ready = can_write; a PPU handshake goes to STREAM.
  - fill_pend beats ppu_valid on the same cycle.
- **STREAM:**
  - ppu_ready = can_write.
  - Handshake (ppu_valid & ppu_ready) writes ppu_code and advances the position.
  - ppu_valid=0 inserts gaps; the position holds.
- **FILL:**
  - ppu_ready = 0.
  - Every cycle with can_write=1 writes fill_reg and advances the position.
- **Position advance:**
  - pix_x increments.
  - At H_PIX−1, pix_x wraps to 0 and pix_y increments.
  - At (H_PIX−1, V_LINES−1), both wrap to 0, frame_done is flagged and the state returns to IDLE.
- **Switching:** requesters change only in IDLE, so a frame is never split between sources. A fill_start mid-STREAM takes effect after that PPU frame completes.
- **fill_busy** = fill_pend | (state == FILL).
- **Width rules:**
  - Position counters are 8-bit and compare against H_PIX−1 and V_LINES−1.
  - fifo_level is compared as unsigned 10-bit.
  - No other arithmetic.

## Timing
- **Reset values:**
  - Applies at the first edge with reset=0.
  - fifo_write=0, fifo_din=0, ppu_ready=0, fill_busy=0, pix_x=0, pix_y=0, frame_done=0.
  - State IDLE; fill_pend cleared.
- **Reset mid-frame:**
  - Abandons the frame; no further writes.
  - Position returns to 0,0.
  - A pending fill is discarded.
- **Output registration:** ppu_ready and fill_busy are combinational from registered state and fifo_level.
- **Write latency:**
  - A handshake or fill beat at edge N produces fifo_write=1 with the data on fifo_din during cycle N+1, for exactly one cycle.
  - fifo_din holds its last value when fifo_write=0.
- **Throughput:** one pixel per cycle max; fill streams back-to-back while can_write=1.
- **Position outputs:** pix_x/pix_y update on the same edge as the accept, so they always name the next pixel.
- **frame_done:**
  - Asserted in the same cycle as the fifo_write carrying the last pixel.
  - Exactly once per frame.
- **Throttling:**
  - Throttling is immediate: can_write=0 drops ppu_ready in the same cycle.
  - HEADROOM absorbs the one in-flight write.
- **Simultaneous events:**
  - fill_start with the last accepted PPU pixel → FILL is entered on the following IDLE cycle.
  - fill_start on the IDLE cycle with ppu_valid=1 → FILL wins; ppu_ready=0.

## Test plan
- **Single PPU frame** (H_PIX=4, V_LINES=3, fifo_level=0, ppu_valid held 1, codes 0..11):
  - 12 fifo_write pulses on consecutive cycles, each one cycle after its accept, fifo_din=0..11.
  - pix_x/pix_y sequence correct.
  - frame_done once, aligned with code 11.
  - State ends IDLE.
- **Backpressure** (fifo_level=508, FIFO_DEPTH=512, HEADROOM=4):
  - ppu_ready=0 and no writes.
  - Drop fifo_level to 507 → ppu_ready=1 the same cycle; write follows next cycle.
- **Mid-frame fill request** (fill_start with fill_code=0x0F after 5 of 12 PPU pixels):
  - Remaining 7 PPU pixels are written.
  - One IDLE cycle follows, then 12 writes of 0x0F, during which ppu_ready=0 despite ppu_valid=1.
  - fill_busy=1 from the request until the last fill write.
- **Arbitration tie** (IDLE, fill_start=1 with fill_code=0x20, ppu_valid=1 on the same cycle):
  - No PPU accept.
  - FILL frame of 0x20 runs first; PPU accepted only after its frame_done.
- **Reset mid-fill** (reset=0 after 6 fill writes):
  - All outputs at reset values next cycle.
  - No further writes.
  - The next PPU pixel is written at pix_x=0, pix_y=0.
- **Full-size wrap** (default params, continuous PPU at fifo_level=0):
  - 61440 writes.
  - pix_x wraps at 255 with pix_y incrementing.
  - frame_done once at the write for (255, 239).
